dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words; SHALL be a power of two, 4..65536.
REQ-002 Parameter LATENCY, default 1: cycles from request acceptance to response; legal range 1..4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; asynchronous and active-low (0 = reset).
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I access type: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle response pulse; no backpressure.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access fault, qualified by rsp_valid.
REQ-014 busy  output  1  a request is outstanding and its response has not yet been issued.

Function
REQ-015 Accept SHALL occur on a rising edge where req_valid and req_ready are both 1; request fields SHALL be captured at that edge.
REQ-016 Only one request SHALL be outstanding; states: IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 in IDLE and RESP, and 0 in WAIT.
REQ-018 Transitions SHALL be: on accept, go to RESP if LATENCY = 1, else to WAIT.
REQ-019 WAIT SHALL last exactly LATENCY-1 cycles, then go to RESP.
REQ-020 RESP SHALL last one cycle, then go to IDLE, or follow REQ-018 if a new request is accepted in that cycle.
REQ-021 rsp_valid SHALL be 1 exactly in RESP, i.e. LATENCY cycles after the accept edge; with LATENCY = 1, sustained throughput SHALL be one request per cycle.
REQ-022 busy SHALL be 1 in WAIT and RESP-with-new-accept pending, i.e. whenever a response is owed.
REQ-023 Word index SHALL be req_addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-024 Fault conditions SHALL be:
- funct3 in {011, 110, 111};
- halfword access with addr[0] = 1;
- word access with addr[1:0] != 00;
- store with funct3 100 or 101.
REQ-025 A faulting request SHALL NOT modify memory, and SHALL respond with rsp_err = 1 and rsp_rdata = 0 after the normal LATENCY.
REQ-026 Stores SHALL commit at the accept edge using byte enables:
- sb: lane addr[1:0], data wdata[7:0];
- sh: lanes addr[1]*2 and +1, data wdata[15:0];
- sw: all four lanes.
Unselected bytes SHALL be unchanged.
REQ-027 Loads SHALL read the word at the accept edge and extract the lane selected by addr[1:0].
- b/h SHALL sign-extend; bu/hu SHALL zero-extend.
- A store followed by a load to the same word SHALL return the stored data.
REQ-028 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.
REQ-029 req_valid while req_ready = 0 SHALL be ignored; the requester holds the request.

Reset
REQ-030 While reset = 0: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
REQ-031 Reset asserted mid-operation SHALL discard any pending response; stores already committed SHALL remain.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-034 LATENCY = 1:
- sw 0xDEADBEEF to addr 0x10, then lw 0x10 -> rsp_valid on the cycle after each accept, rdata 0xDEADBEEF;
- back-to-back requests SHALL show no idle cycles.
REQ-035 Byte lanes: sb 0x80 to 0x13, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
REQ-036 Faults:
- lw 0x12 -> rsp_err = 1, rdata = 0;
- sh 0x11 -> rsp_err = 1, and a following lw 0x10 SHALL be unchanged;
- funct3 = 011 -> rsp_err = 1.
REQ-037 LATENCY = 3:
- req_ready low for 2 cycles after accept; rsp_valid 3 cycles after accept;
- a new request accepted in the RESP cycle SHALL respond 3 cycles later.
REQ-038 Wrap, DEPTH = 64: sw 0x11223344 to addr 0x100, then lw 0x000 -> 0x11223344.
REQ-039 Reset mid-op, LATENCY = 3: assert reset 1 cycle after an lw accept -> no rsp_valid ever for that request; all outputs 0 and req_ready = 1 during reset.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a load/store requester and dmem_ctrl.
// One request in flight at a time; the response is a single-cycle pulse with no backpressure.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: byte/half/word loads and stores into a DEPTH x 32 array,
// with a fixed LATENCY from request acceptance to a one-cycle response.
module dmem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic          ready;
    logic          accept;
    logic          fault;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [3:0]    be;
    logic [31:0]   wdata_lane;
    logic          unused_addr_bits;

    function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  is_fault = 1'b0;
            3'b001:  is_fault = off[0];
            3'b010:  is_fault = (off != 2'b00);
            3'b100:  is_fault = we;
            3'b101:  is_fault = we | off[0];
            default: is_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = word >> {off, 3'b000};
        half    = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_extract = {24'h0, shifted[7:0]};
            3'b001:  load_extract = {{16{half[15]}}, half};
            3'b101:  load_extract = {16'h0, half};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_be = 4'b0001 << off;
            3'b001:  store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  store_data = {4{wd[7:0]}};
            3'b001:  store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    assign idx              = bus.req_addr[AW+1:2];
    assign rd_word          = mem_q[idx];
    assign fault            = is_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign be               = store_be(bus.req_funct3, bus.req_addr[1:0]);
    assign wdata_lane       = store_data(bus.req_funct3, bus.req_wdata);
    assign unused_addr_bits = ^bus.req_addr[31:AW+2];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        ready         = (state_q != ST_WAIT);
        accept        = bus.req_valid && ready;
        bus.req_ready = ready;
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
        bus.rsp_err   = (state_q == ST_RESP) && err_q;
        bus.busy      = (state_q == ST_WAIT) || ((state_q == ST_RESP) && bus.req_valid);

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 2'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: ;
        endcase

        // Accept is only possible outside WAIT, so it safely overrides the RESP->IDLE step.
        if (accept) begin
            state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            cnt_d   = CNT_INIT;
            err_d   = fault;
            rdata_d = (fault || bus.req_we) ? 32'h0
                                            : load_extract(rd_word, bus.req_funct3, bus.req_addr[1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response payload is masked by state at the outputs, so it needs no reset.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a LATENCY=1 and a LATENCY=3 instance, each with a scoreboard queue
// filled at request issue and drained by a response monitor sampling on the falling edge.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   st;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] m [16];

    dmem_ctrl_if if1();
    dmem_ctrl_if if3();

    dmem_ctrl #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(if1));
    dmem_ctrl #(.DEPTH(64), .LATENCY(3)) u_dut_l3 (.clk(clk), .reset(reset), .bus(if3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d, required finish", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3;
            if3.req_addr  = a; if3.req_wdata = wd;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_funct3 = f3;
            if1.req_addr  = a; if1.req_wdata = wd;
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic issue(input bit sel, input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                         output int stalls);
        exp_t e;
        logic rdy;
        stalls = 0;
        drive(sel, 1'b1, we, f3, a, wd);
        rdy = sel ? if3.req_ready : if1.req_ready;
        while (rdy !== 1'b1 && stalls < 20) begin
            @(negedge clk);
            stalls++;
            rdy = sel ? if3.req_ready : if1.req_ready;
        end
        check_eq(sel ? "l3_ready_at_issue" : "l1_ready_at_issue", rdy, 1'b1);
        if (rdy === 1'b1) begin
            e.rd  = erd;
            e.err = eerr;
            e.due = cyc + (sel ? 3 : 1);
            if (sel) q3.push_back(e);
            else     q1.push_back(e);
            @(negedge clk);
        end
        drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic l1(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr);
        issue(1'b0, we, f3, a, wd, erd, eerr, st);
    endtask

    task automatic l3(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr);
        issue(1'b1, we, f3, a, wd, erd, eerr, st);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_q1", 32'(q1.size()), 32'd0);
        check_eq("drain_q3", 32'(q3.size()), 32'd0);
    endtask

    // Reference behaviour for the word region 0x80..0xBF (m[] holds words 32..47).
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        logic [31:0] w, s;
        logic [15:0] h;
        int          i;
        i   = int'(a[5:2]);
        w   = m[i];
        rd  = 32'h0;
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
              (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) ||
              ((f3 == 3'd2) && (a[1:0] != 2'b00)) ||
              (we && ((f3 == 3'd4) || (f3 == 3'd5)));
        if (!err && we) begin
            case (f3)
                3'd0:    w[8*a[1:0] +: 8]  = wd[7:0];
                3'd1:    w[16*a[1] +: 16]  = wd[15:0];
                default: w = wd;
            endcase
            m[i] = w;
        end else if (!err) begin
            s = w >> (8 * a[1:0]);
            h = a[1] ? w[31:16] : w[15:0];
            case (f3)
                3'd0:    rd = {{24{s[7]}}, s[7:0]};
                3'd4:    rd = {24'h0, s[7:0]};
                3'd1:    rd = {{16{h[15]}}, h};
                3'd5:    rd = {16'h0, h};
                default: rd = w;
            endcase
        end
    endtask

    always @(negedge clk) begin : mon_l1
        exp_t e;
        if (if1.rsp_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check_eq("l1_unexpected_rsp_outstanding", 32'(q1.size()), 32'd1);
            end else begin
                e = q1.pop_front();
                check_eq("l1_rdata", if1.rsp_rdata, e.rd);
                check_eq("l1_err", if1.rsp_err, e.err);
                check_eq("l1_latency_cycle", cyc, e.due);
            end
        end else begin
            check_eq("l1_idle_rdata", if1.rsp_rdata, 32'h0);
            check_eq("l1_idle_err", if1.rsp_err, 1'b0);
        end
    end

    always @(negedge clk) begin : mon_l3
        exp_t e;
        if (if3.rsp_valid === 1'b1) begin
            if (q3.size() == 0) begin
                check_eq("l3_unexpected_rsp_outstanding", 32'(q3.size()), 32'd1);
            end else begin
                e = q3.pop_front();
                check_eq("l3_rdata", if3.rsp_rdata, e.rd);
                check_eq("l3_err", if3.rsp_err, e.err);
                check_eq("l3_latency_cycle", cyc, e.due);
            end
        end else begin
            check_eq("l3_idle_rdata", if3.rsp_rdata, 32'h0);
            check_eq("l3_idle_err", if3.rsp_err, 1'b0);
        end
    end

    initial begin
        int          c0;
        logic [2:0]  f3_tab [12];
        logic [2:0]  f3;
        logic [31:0] a, wd, erd;
        logic        eerr;
        bit          we;

        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("rst_l1_ready", if1.req_ready, 1'b1);
        check_eq("rst_l1_rsp_valid", if1.rsp_valid, 1'b0);
        check_eq("rst_l1_busy", if1.busy, 1'b0);
        check_eq("rst_l3_ready", if3.req_ready, 1'b1);
        check_eq("rst_l3_rsp_valid", if3.rsp_valid, 1'b0);
        check_eq("rst_l3_busy", if3.busy, 1'b0);

        // First accept on the first rising edge after release; then a fully back-to-back run.
        reset = 1'b1;
        c0 = cyc;
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, st);
        check_eq("l1_first_accept_stalls", 32'(st), 32'd0);
        l1(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        l1(1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0,        1'b0);
        l1(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
        l1(1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0);
        l1(1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
        l1(1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1);
        l1(1'b1, 3'b001, 32'h11, 32'h0000AAAA, 32'h0,        1'b1);
        l1(1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
        l1(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1);
        l1(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0);
        l1(1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
        l1(1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
        l1(1'b0, 3'b100, 32'h11, 32'h0,        32'h000000BE, 1'b0);
        l1(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        1'b0);
        l1(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1);
        l1(1'b0, 3'b010, 32'h10, 32'h0,        32'h1234BEEF, 1'b0);
        l1(1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0,       1'b0);
        l1(1'b0, 3'b010, 32'h000, 32'h0,        32'h11223344, 1'b0);
        l1(1'b0, 3'b010, 32'h80000000, 32'h0,   32'h11223344, 1'b0);
        check_eq("l1_back_to_back_cycles", 32'(cyc - c0), 32'd20);
        drain();

        // Randomised traffic over a pre-filled region, with random ignored upper address bits.
        for (int i = 0; i < 16; i++) begin
            a  = 32'h80 + 32'(4 * i);
            wd = $urandom();
            model(1'b1, 3'd2, a, wd, erd, eerr);
            l1(1'b1, 3'd2, a, wd, erd, eerr);
        end
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 11)];
            a  = {$urandom(), 8'h0} | {24'h0, 2'b10, 6'($urandom_range(0, 63))};
            a[7:6] = 2'b10;
            wd = $urandom();
            model(we, f3, a, wd, erd, eerr);
            l1(we, f3, a, wd, erd, eerr);
        end
        drain();

        l3(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        check_eq("l3_ready_wait1", if3.req_ready, 1'b0);
        check_eq("l3_busy_wait1", if3.busy, 1'b1);
        @(negedge clk);
        check_eq("l3_ready_wait2", if3.req_ready, 1'b0);
        @(negedge clk);
        check_eq("l3_ready_resp", if3.req_ready, 1'b1);
        check_eq("l3_busy_resp_no_req", if3.busy, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        #1;
        check_eq("l3_busy_resp_with_req", if3.busy, 1'b1);
        l3(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        check_eq("l3_ready_after_resp_accept", if3.req_ready, 1'b0);
        l3(1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
        l3(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000CAFE, 1'b0);
        drain();

        // Reset one cycle after a load is accepted: its response must never appear.
        l3(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        reset = 1'b0;
        q3.delete();
        #1;
        check_eq("midrst_l3_ready", if3.req_ready, 1'b1);
        check_eq("midrst_l3_rsp_valid", if3.rsp_valid, 1'b0);
        check_eq("midrst_l3_rdata", if3.rsp_rdata, 32'h0);
        check_eq("midrst_l3_err", if3.rsp_err, 1'b0);
        check_eq("midrst_l3_busy", if3.busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, st);
        check_eq("post_rst_first_accept_stalls", 32'(st), 32'd0);
        repeat (6) @(negedge clk);
        l3(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        l1(1'b0, 3'b010, 32'h000, 32'h0, 32'h11223344, 1'b0);
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
